// File: rtl/bs_dispatch_pkg.sv
// Shared types and BS_ID decode for the dispatch arbiter.
// BS_DISPATCH_BCAST_EN enables the 0xFF broadcast mapping.
package bs_dispatch_pkg;

  localparam int NUM_DST     = 3;
  localparam int DST_XMULT_0 = 0;
  localparam int DST_AUROR_0 = 1;
  localparam int DST_AUROR_1 = 2;

  localparam logic [7:0] BS_ID_XMULT_0 = 8'h00;
  localparam logic [7:0] BS_ID_AUROR_0 = 8'h03;
  localparam logic [7:0] BS_ID_AUROR_1 = 8'h02;
  localparam logic [7:0] BS_ID_BROAD_0 = 8'hFF;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef logic [NUM_DST-1:0] dst_mask_t;

  typedef enum logic {
    ARB  = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // An empty mask means the packet is dropped.
  function automatic dst_mask_t bs_id_to_mask(
    input logic [7:0] bs_id
  );
    dst_mask_t m;
    m = '0;
    unique case (1'b1)
      (bs_id == BS_ID_XMULT_0): m[DST_XMULT_0] = 1'b1;
      (bs_id == BS_ID_AUROR_0): m[DST_AUROR_0] = 1'b1;
      (bs_id == BS_ID_AUROR_1): m[DST_AUROR_1] = 1'b1;
`ifdef BS_DISPATCH_BCAST_EN
      (bs_id == BS_ID_BROAD_0): m = '1;
`endif
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bs_dispatch_arbiter_pick.sv
// Rotating-priority one-hot selector: first request
// at or after base, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(base) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

endmodule

// File: rtl/bs_dispatch_arbiter.sv
// Round-robin packet dispatch from NUM_SRC FWFT FIFOs to
// XMULT_0 / AUROR_0 / AUROR_1 (BS_DISPATCH_BCAST_EN: broadcast).
module bs_dispatch_arbiter
  import bs_dispatch_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 256
) (
  input  logic                      clk_200MHz,
  input  logic                      peripheral_reset,
  input  logic [NUM_SRC-1:0]        src_not_empty,
  output logic [NUM_SRC-1:0]        src_rd_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_dout,
  input  logic [NUM_DST-1:0]        dst_full,
  output logic [NUM_DST-1:0]        dst_wr_en,
  output logic [DATA_W-1:0]         dst_din,
  output logic [15:0]               drop_cnt,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SRC - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] lock_q, lock_d;

  dst_mask_t        src_mask [NUM_SRC];
  logic [NUM_SRC-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;

  logic             pop;
  logic [PTR_W-1:0] pop_idx;
  dst_mask_t        pop_mask;
  logic [DATA_W-1:0] pop_pkt;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_mask[i] = bs_id_to_mask(
        src_dout[i*DATA_W + DATA_W - 8 +: 8]);
    end
  end

  rr_priority_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .req   (src_not_empty),
    .base  (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    pop       = 1'b0;
    pop_idx   = pick_idx;
    src_rd_en = '0;
    unique case (state_q)
      ARB: begin
        if (pick_valid) begin
          if ((src_mask[pick_idx] & dst_full) == '0) begin
            pop      = 1'b1;
            rr_ptr_d = ptr_inc(pick_idx);
          end else begin
            lock_d  = pick_idx;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // FWFT data of the locked source is stable here.
        pop_idx = lock_q;
        if ((src_mask[lock_q] & dst_full) == '0) begin
          pop      = 1'b1;
          rr_ptr_d = ptr_inc(lock_q);
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (peripheral_reset) pop = 1'b0;
    if (pop) src_rd_en[pop_idx] = 1'b1;
  end

  always_comb begin
    pop_mask = src_mask[pop_idx];
    pop_pkt  = src_dout[int'(pop_idx)*DATA_W +: DATA_W];
  end

  assign busy = (state_q == WAIT);

  always_ff @(posedge clk_200MHz) begin
    if (peripheral_reset) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      lock_q    <= '0;
      dst_wr_en <= '0;
      dst_din   <= '0;
      drop_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      dst_wr_en <= pop ? pop_mask : '0;
      if (pop && pop_mask != '0) dst_din <= pop_pkt;
      if (pop && pop_mask == '0 && drop_cnt != DROP_MAX)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bs_dispatch_arbiter.sv
// Directed bench for bs_dispatch_arbiter (4 sources,
// 256-bit packets); honours BS_DISPATCH_BCAST_EN.
module tb_bs_dispatch_arbiter;

  localparam int NS = 4;
  localparam int DW = 256;

  logic              clk_200MHz = 1'b0;
  logic              peripheral_reset;
  logic [NS-1:0]     src_not_empty;
  logic [NS-1:0]     src_rd_en;
  logic [NS*DW-1:0]  src_dout;
  logic [2:0]        dst_full;
  logic [2:0]        dst_wr_en;
  logic [DW-1:0]     dst_din;
  logic [15:0]       drop_cnt;
  logic              busy;

  logic [DW-1:0]     pkt [NS];
  int                total = 0;
  int                bad = 0;
  logic              any_wr;
  logic [3:0]        t2_gnt [5];
  int                t2_src [5];

  always #5 clk_200MHz = ~clk_200MHz;

  always_comb src_dout = {pkt[3], pkt[2], pkt[1], pkt[0]};

  bs_dispatch_arbiter #(
    .NUM_SRC (NS),
    .DATA_W  (DW)
  ) dut (
    .clk_200MHz       (clk_200MHz),
    .peripheral_reset (peripheral_reset),
    .src_not_empty    (src_not_empty),
    .src_rd_en        (src_rd_en),
    .src_dout         (src_dout),
    .dst_full         (dst_full),
    .dst_wr_en        (dst_wr_en),
    .dst_din          (dst_din),
    .drop_cnt         (drop_cnt),
    .busy             (busy)
  );

  function automatic logic [DW-1:0] mk(
    input logic [7:0] id,
    input int s
  );
    logic [7:0] sb;
    sb = 8'(s);
    return {id, sb, 48'hA5A5_0000_1234,
            {6{32'hC0DE_0000 ^ 32'(s)}}};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(
    input string tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_200MHz);
    #1;
  endtask

  task automatic do_reset();
    peripheral_reset = 1'b1;
    tick();
    peripheral_reset = 1'b0;
  endtask

  initial begin
    peripheral_reset = 1'b1;
    src_not_empty    = '0;
    dst_full         = '0;
    for (int i = 0; i < NS; i++) pkt[i] = '0;
    t2_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t2_src = '{0, 1, 2, 3, 0};
    tick();
    tick();
    chk("rst_wr", 32'(dst_wr_en), 0);
    chkd("rst_din", dst_din, '0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(src_rd_en), 0);
    peripheral_reset = 1'b0;
    #1;
    chk("idle_rd", 32'(src_rd_en), 0);

    // single packet to AUROR_1 from source 1
    pkt[1] = mk(8'h02, 1);
    src_not_empty = 4'b0010;
    #1;
    chk("t1_rd", 32'(src_rd_en), 'b0010);
    tick();
    src_not_empty = '0;
    chk("t1_wr", 32'(dst_wr_en), 'b100);
    chkd("t1_din", dst_din, mk(8'h02, 1));
    tick();
    chk("t1_wr_off", 32'(dst_wr_en), 0);

    // all sources pending, round-robin from 0
    do_reset();
    for (int s = 0; s < NS; s++) pkt[s] = mk(8'h00, 10 + s);
    src_not_empty = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t2_rd", 32'(src_rd_en), 32'(t2_gnt[c]));
      tick();
      chk("t2_wr", 32'(dst_wr_en), 'b001);
      chkd("t2_din", dst_din, mk(8'h00, 10 + t2_src[c]));
    end
    src_not_empty = '0;
    tick();
    chk("t2_wr_off", 32'(dst_wr_en), 0);

    // rr_ptr=1: source 2 blocked on AUROR_0, source 3 waits
    pkt[2] = mk(8'h03, 20);
    pkt[3] = mk(8'h00, 30);
    src_not_empty = 4'b1100;
    dst_full = 3'b010;
    #1;
    chk("t3_arb_rd", 32'(src_rd_en), 0);
    chk("t3_arb_busy", 32'(busy), 0);
    tick();
    repeat (5) begin
      chk("t3_busy", 32'(busy), 1);
      #1;
      chk("t3_hold_rd", 32'(src_rd_en), 0);
      tick();
      chk("t3_hold_wr", 32'(dst_wr_en), 0);
    end
    dst_full = '0;
    #1;
    chk("t3_rd2", 32'(src_rd_en), 'b0100);
    chk("t3_busy_last", 32'(busy), 1);
    tick();
    src_not_empty = 4'b1000;
    chk("t3_wr2", 32'(dst_wr_en), 'b010);
    chkd("t3_din2", dst_din, mk(8'h03, 20));
    chk("t3_busy_off", 32'(busy), 0);
    #1;
    chk("t3_rd3", 32'(src_rd_en), 'b1000);
    tick();
    src_not_empty = '0;
    chk("t3_wr3", 32'(dst_wr_en), 'b001);
    chkd("t3_din3", dst_din, mk(8'h00, 30));

    // broadcast id on source 0 (rr_ptr=0), XMULT_0 full
    pkt[0] = mk(8'hFF, 40);
    src_not_empty = 4'b0001;
    dst_full = 3'b001;
`ifdef BS_DISPATCH_BCAST_EN
    #1;
    chk("t4_rd_blk", 32'(src_rd_en), 0);
    tick();
    chk("t4_busy", 32'(busy), 1);
    dst_full = '0;
    #1;
    chk("t4_rd", 32'(src_rd_en), 'b0001);
    tick();
    src_not_empty = '0;
    chk("t4_wr", 32'(dst_wr_en), 'b111);
    chkd("t4_din", dst_din, mk(8'hFF, 40));
    chk("t4_drop", 32'(drop_cnt), 0);
`else
    #1;
    chk("t4_rd", 32'(src_rd_en), 'b0001);
    tick();
    src_not_empty = '0;
    chk("t4_wr", 32'(dst_wr_en), 0);
    chk("t4_drop", 32'(drop_cnt), 1);
    chk("t4_busy", 32'(busy), 0);
`endif
    dst_full = '0;
    tick();

    // drop counter saturation
    do_reset();
    chk("t5_drop0", 32'(drop_cnt), 0);
    pkt[0] = mk(8'h7A, 50);
    src_not_empty = 4'b0001;
    #1;
    chk("t5_rd", 32'(src_rd_en), 'b0001);
    any_wr = 1'b0;
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (dst_wr_en != '0) any_wr = 1'b1;
      if (n == 65534) chk("t5_fffe", 32'(drop_cnt), 'hFFFE);
      if (n == 65535) chk("t5_ffff", 32'(drop_cnt), 'hFFFF);
    end
    src_not_empty = '0;
    chk("t5_nowr", 32'(any_wr), 0);
    chk("t5_hold", 32'(drop_cnt), 'hFFFF);

    // reset right after a pop
    do_reset();
    pkt[2] = mk(8'h00, 60);
    src_not_empty = 4'b0100;
    #1;
    chk("t6_rd", 32'(src_rd_en), 'b0100);
    tick();
    chk("t6_pending", 32'(dst_wr_en), 'b001);
    peripheral_reset = 1'b1;
    pkt[1] = mk(8'h00, 61);
    pkt[3] = mk(8'h00, 63);
    src_not_empty = 4'b1010;
    #1;
    chk("t6_rst_rd", 32'(src_rd_en), 0);
    tick();
    peripheral_reset = 1'b0;
    chk("t6_wr_drop", 32'(dst_wr_en), 0);
    chk("t6_busy", 32'(busy), 0);
    #1;
    chk("t6_rd_low", 32'(src_rd_en), 'b0010);
    tick();
    src_not_empty = '0;
    chk("t6_wr", 32'(dst_wr_en), 'b001);
    chkd("t6_din", dst_din, mk(8'h00, 61));

    // reset releases a lock held in WAIT
    pkt[0] = mk(8'h03, 70);
    src_not_empty = 4'b0001;
    dst_full = 3'b010;
    tick();
    chk("t7_busy", 32'(busy), 1);
    do_reset();
    chk("t7_busy_off", 32'(busy), 0);
    pkt[1] = mk(8'h00, 71);
    src_not_empty = 4'b0010;
    #1;
    chk("t7_rd", 32'(src_rd_en), 'b0010);
    tick();
    src_not_empty = '0;
    dst_full = '0;
    chk("t7_wr", 32'(dst_wr_en), 'b001);
    chkd("t7_din", dst_din, mk(8'h00, 71));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bs_dispatch_arbiter.md
# bs_dispatch_arbiter

Round-robin arbiter that shares the packet dispatch path between NUM_SRC packet source FIFOs and routes each 256-bit packet to the matrix-multiplier FIFO or one of the two Aurora TX FIFOs by its BS_ID header byte. It sits between the host/Aurora RX FIFOs and the XMULT_0 / AUROR_0 / AUROR_1 inputs in the clk_200MHz domain. Broadcast packets (BS_ID 0xFF) are copied to all three destinations. Packets with unknown BS_IDs are dropped and counted.

## Interface
- NUM_SRC, 4: number of source FIFOs, 2..8
- DATA_W, 256: packet width; the header occupies [255:192]
- clk_200MHz  in  1  sole clock
- peripheral_reset  in  1  synchronous, active-high reset
- src_not_empty  in  NUM_SRC  per-source FWFT FIFO has a packet on src_dout
- src_rd_en  out  NUM_SRC  pop strobe, one-hot or zero, combinational
- src_dout  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- dst_full  in  3  destination prog-full; index 0=XMULT_0, 1=AUROR_0, 2=AUROR_1; must assert with ≥2 free entries
- dst_wr_en  out  3  registered write strobes
- dst_din  out  DATA_W  registered packet bus, shared by all destinations
- drop_cnt  out  16  saturating count of dropped packets
- busy  out  1  high while in WAIT state

## Operation
- BS_ID = packet[255:248]. Destination map:
  - 0x00 → dest 0
  - 0x03 → dest 1
  - 0x02 → dest 2
  - 0xFF → dests {0,1,2} when BCAST_EN is defined
  - Any other value → drop
- FSM states: ARB, WAIT.
  - ARB: scan sources starting at rr_ptr, in increasing index with wrap. The first source with src_not_empty=1 is the candidate.
    - Candidate's destination mask all not full (or mask empty, i.e. drop): assert its src_rd_en this cycle, set rr_ptr = candidate+1 mod NUM_SRC, stay in ARB.
    - Otherwise: latch the candidate index as locked, go to WAIT, no pop.
  - WAIT: only the locked source is considered.
    - Pop it when every bit of its mask has dst_full=0, then rr_ptr = locked+1 and return to ARB.
    - No other source is served meanwhile (strict order, no partial broadcast).
- Write path: the cycle after a pop with a nonzero mask, dst_din = popped packet and dst_wr_en = mask, for exactly one cycle.
- Drop path: a pop with an empty mask produces no write. drop_cnt increments and holds at 0xFFFF.
- Packets are never modified; header and payload pass through bit-exact.
- Throughput: one packet per cycle when destinations have room.

## Timing
- Reset values: src_rd_en=0, dst_wr_en=0, dst_din=0, drop_cnt=0, busy=0, rr_ptr=0, state=ARB.
- Pop-to-write latency is 1 cycle. dst_full is sampled in the pop cycle only; the prog-full margin absorbs the in-flight write.
- src_rd_en depends combinationally on src_not_empty, src_dout[255:248], dst_full, state and rr_ptr. There is no path from dst_wr_en.
- Simultaneous requests: the winner is the lowest index at or after rr_ptr.
- The lock persists in WAIT even if the locked source's src_not_empty falls; FWFT data is held, so the source cannot drop.
- Reset mid-operation:
  - A pending registered write is discarded (dst_wr_en=0 the next cycle).
  - The lock is released.
  - No src_rd_en is issued in the reset cycle.
- drop_cnt saturates; it never wraps.

## Configuration
- BS_DISPATCH_BCAST_EN defined: BS_ID 0xFF maps to mask 3'b111. The pop waits until all three dst_full bits are 0, then writes all three in the same cycle.
- Undefined: 0xFF is treated as unknown. It is popped, not written, and drop_cnt increments.

## Structure
- Shared package bs_dispatch_pkg holds:
  - BS_ID constants: BS_ID_XMULT_0=8'h00, BS_ID_AUROR_0=8'h03, BS_ID_AUROR_1=8'h02, BS_ID_BROAD_0=8'hFF
  - Destination index constants
  - State enum {ARB, WAIT}
  - Function bs_id_to_mask(bs_id) → 3-bit mask
- One sub-module: rr_priority_pick, a parameterised rotating-priority one-hot selector over NUM_SRC with base pointer input.

## Test plan
- Reset then idle: all outputs 0. A packet of BS_ID 0x02 on source 1 → src_rd_en=4'b0010 on the first cycle, then dst_wr_en=3'b100 with dst_din identical 1 cycle later.
- All 4 sources continuously not_empty with BS_ID 0x00, dest free → pops in order 0,1,2,3,0 on consecutive cycles, dst_wr_en=3'b001 every cycle.
- Source 2 holds BS_ID 0x03 while dst_full=3'b010 for 5 cycles, and source 3 is also pending → busy=1 for 5 cycles, no pops. Source 2 pops on the cycle dst_full clears, then source 3 pops next.
- BS_ID 0xFF with the macro defined and dst_full=3'b001 → WAIT. Once clear, a single write has dst_wr_en=3'b111. Without the macro → no write, drop_cnt=1.
- 70000 packets with BS_ID 0x7A → no writes, drop_cnt reaches and holds 16'hFFFF.
- Assert peripheral_reset in the cycle after a pop → dst_wr_en stays 0, rr_ptr=0, and the next winner is the lowest pending source.
